// File: rtl/uart_ctrl_pkg.sv
// Shared types and constants for the UART transmit control path.
// State encoding, frame length and bit-timing helper.
package uart_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_BUSY   = 2'd2,
        ST_GAP    = 2'd3
    } state_t;

    localparam int BPF = 10;

    function automatic int cycles_per_bit(input int sys_clk_freq, input int bps);
        return sys_clk_freq / bps;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin winner select.
// Searches upward from last_grant+1, wrapping modulo NUM_REQ.
module rr_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int IDW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     last_grant,
    output logic [IDW-1:0]     winner,
    output logic               any_req
);

    int idx;

    // Walk farthest-first so the nearest set bit is the last one written.
    always_comb begin
        winner = '0;
        idx    = 0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = (int'(last_grant) + i) % NUM_REQ;
            if (req[IDW'(idx)])
                winner = IDW'(idx);
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one 8N1 UART transmitter among NUM_REQ clients.
// Define UART_ARB_TIMEOUT_EN to build the BUSY-state abort counter.
module uart_tx_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int width          = 8,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 60000,
    localparam int IDW = $clog2(NUM_REQ)
) (
    input  logic                     sys_clk,
    input  logic                     sys_reset_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*width-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [NUM_REQ-1:0]       req_done,
    output logic                     uart_tx_en,
    output logic [width-1:0]         uart_tx_data,
    input  logic                     uart_tx_done,
    output logic                     busy,
    output logic [IDW-1:0]           grant_id,
    output logic                     timeout_err
);

    state_t state, state_nxt;

    logic [IDW-1:0]     last_grant;
    logic [IDW-1:0]     win;
    logic               any_req;
    logic [31:0]        gap_cnt;
    logic               timeout_hit;
    logic [NUM_REQ-1:0] ready_d;
    logic [NUM_REQ-1:0] done_d;
    logic               en_d;
    logic               terr_d;
    logic               busy_d;
    logic [width-1:0]   data_d;
    logic [IDW-1:0]     gid_d;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_rr (
        .req        (req_valid),
        .last_grant (last_grant),
        .winner     (win),
        .any_req    (any_req)
    );

`ifdef UART_ARB_TIMEOUT_EN
    logic [31:0] busy_cnt;

    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n)
            busy_cnt <= '0;
        else if (state == ST_LAUNCH)
            busy_cnt <= '0;
        else if (state == ST_BUSY)
            busy_cnt <= busy_cnt + 32'd1;
    end

    assign timeout_hit = (state == ST_BUSY) &&
                         (busy_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            state   <= ST_IDLE;
            gap_cnt <= '0;
        end else begin
            state   <= state_nxt;
            gap_cnt <= (state == ST_GAP) ? gap_cnt + 32'd1 : '0;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:   if (any_req) state_nxt = ST_LAUNCH;
            ST_LAUNCH: state_nxt = ST_BUSY;
            ST_BUSY:
                if (uart_tx_done || timeout_hit)
                    state_nxt = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
            ST_GAP:
                if (gap_cnt == 32'(GAP_CYCLES - 1))
                    state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Next values for the registered outputs; done takes priority over abort.
    always_comb begin
        ready_d = '0;
        done_d  = '0;
        en_d    = 1'b0;
        terr_d  = 1'b0;
        data_d  = uart_tx_data;
        gid_d   = grant_id;
        busy_d  = (state_nxt != ST_IDLE);
        unique case (state)
            ST_IDLE:
                if (any_req) begin
                    en_d         = 1'b1;
                    gid_d        = win;
                    ready_d[win] = 1'b1;
                    for (int i = 0; i < NUM_REQ; i++)
                        if (win == IDW'(i))
                            data_d = req_data[i*width +: width];
                end
            ST_BUSY:
                if (uart_tx_done)
                    done_d[grant_id] = 1'b1;
                else if (timeout_hit)
                    terr_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            req_ready    <= '0;
            req_done     <= '0;
            uart_tx_en   <= 1'b0;
            uart_tx_data <= '0;
            busy         <= 1'b0;
            grant_id     <= '0;
            timeout_err  <= 1'b0;
            last_grant   <= IDW'(NUM_REQ - 1);
        end else begin
            req_ready    <= ready_d;
            req_done     <= done_d;
            uart_tx_en   <= en_d;
            uart_tx_data <= data_d;
            busy         <= busy_d;
            grant_id     <= gid_d;
            timeout_err  <= terr_d;
            if (en_d)
                last_grant <= win;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small 8N1 transmitter model.
// Timeout scenario is exercised when UART_ARB_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    localparam int NR  = 4;
    localparam int W   = 8;
    localparam int GAP = 2;
    localparam int TMO = 100;
    localparam int CPB = 4;

    logic          sys_clk = 1'b0;
    logic          sys_reset_n = 1'b0;
    logic [NR-1:0] req_valid = '0;
    logic [NR*W-1:0] req_data = '0;
    logic [NR-1:0] req_ready;
    logic [NR-1:0] req_done;
    logic          uart_tx_en;
    logic [W-1:0]  uart_tx_data;
    logic          uart_tx_done;
    logic          busy;
    logic [1:0]    grant_id;
    logic          timeout_err;

    logic spur = 1'b0;
    logic block_done = 1'b0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    uart_tx_arbiter #(
        .NUM_REQ(NR),
        .width(W),
        .GAP_CYCLES(GAP),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_reset_n  (sys_reset_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .req_done     (req_done),
        .uart_tx_en   (uart_tx_en),
        .uart_tx_data (uart_tx_data),
        .uart_tx_done (uart_tx_done),
        .busy         (busy),
        .grant_id     (grant_id),
        .timeout_err  (timeout_err)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // Transmitter model: start, 8 data LSB first, stop; done on last stop cycle.
    logic       tx_active;
    logic [3:0] tx_idx;
    logic [7:0] tx_cyc;
    logic [9:0] tx_sh;
    logic       tx_line;

    always @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            tx_active <= 1'b0;
            tx_idx    <= '0;
            tx_cyc    <= '0;
            tx_sh     <= '1;
        end else if (uart_tx_en && !tx_active) begin
            tx_active <= 1'b1;
            tx_idx    <= '0;
            tx_cyc    <= '0;
            tx_sh     <= {1'b1, uart_tx_data, 1'b0};
        end else if (tx_active) begin
            if (tx_cyc == 8'(CPB - 1)) begin
                tx_cyc <= '0;
                if (tx_idx == 4'd9) tx_active <= 1'b0;
                else tx_idx <= tx_idx + 4'd1;
            end else begin
                tx_cyc <= tx_cyc + 8'd1;
            end
        end
    end

    assign tx_line = tx_active ? tx_sh[tx_idx] : 1'b1;
    assign uart_tx_done = (tx_active && tx_idx == 4'd9 &&
                           tx_cyc == 8'(CPB - 1) && !block_done) || spur;

    logic ready2_seen = 1'b0;
    logic terr_seen = 1'b0;
    int   done_pulses = 0;

    always @(negedge sys_clk) begin
        if (req_ready[2]) ready2_seen <= 1'b1;
        if (timeout_err) terr_seen <= 1'b1;
        if (req_done != '0) done_pulses <= done_pulses + 1;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic apply_reset();
        sys_reset_n = 1'b0;
        req_valid = '0;
        spur = 1'b0;
        block_done = 1'b0;
        tick(3);
        sys_reset_n = 1'b1;
        tick(1);
    endtask

    task automatic wait_en(input string tag);
        int k = 0;
        while (!uart_tx_en && k < 300) begin
            tick(1);
            k++;
        end
        checks++;
        if (!uart_tx_en) begin
            failures++;
            $display("FAIL %s_wait_en: got no launch within 300 cycles, expected uart_tx_en=1", tag);
        end
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (req_done == '0 && k < 300) begin
            tick(1);
            k++;
        end
        checks++;
        if (req_done == '0) begin
            failures++;
            $display("FAIL %s_wait_done: got no req_done within 300 cycles, expected a pulse", tag);
        end
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (busy && k < 300) begin
            tick(1);
            k++;
        end
        checks++;
        if (busy) begin
            failures++;
            $display("FAIL %s_wait_idle: busy stuck at 1, expected 0 within 300 cycles", tag);
        end
    endtask

    task automatic test_reset();
        sys_reset_n = 1'b0;
        req_valid = '0;
        tick(3);
        checks++;
        if ({uart_tx_en, req_ready, req_done, busy, timeout_err} !== 11'd0) begin
            failures++;
            $display("FAIL reset_ctrl: got en=%b ready=%b done=%b busy=%b terr=%b, expected all 0",
                     uart_tx_en, req_ready, req_done, busy, timeout_err);
        end
        checks++;
        if (uart_tx_data !== 8'h00 || grant_id !== 2'd0) begin
            failures++;
            $display("FAIL reset_data: got data=%h gid=%0d, expected 00 and 0", uart_tx_data, grant_id);
        end
        sys_reset_n = 1'b1;
        tick(1);
    endtask

    task automatic test_single_frame();
        logic [9:0] exp_line = 10'b1101001010;
        logic [9:0] got;
        apply_reset();
        req_data[7:0] = 8'hA5;
        req_valid = 4'b0001;
        tick(1);
        checks++;
        if (uart_tx_en !== 1'b1 || req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL single_launch: got en=%b ready=%b, expected en=1 ready=0001", uart_tx_en, req_ready);
        end
        checks++;
        if (uart_tx_data !== 8'hA5 || busy !== 1'b1 || grant_id !== 2'd0) begin
            failures++;
            $display("FAIL single_data: got data=%h busy=%b gid=%0d, expected A5 1 0",
                     uart_tx_data, busy, grant_id);
        end
        req_valid = '0;
        tick(1);
        checks++;
        if (uart_tx_en !== 1'b0 || req_ready !== 4'b0000) begin
            failures++;
            $display("FAIL single_pulse_width: got en=%b ready=%b, expected 0 and 0000", uart_tx_en, req_ready);
        end
        for (int b = 0; b < 10; b++) begin
            got[b] = tx_line;
            if (b < 9) tick(CPB);
        end
        checks++;
        if (got !== exp_line) begin
            failures++;
            $display("FAIL single_serial: got bits(9..0)=%b, expected %b", got, exp_line);
        end
        tick(CPB - 1);
        checks++;
        if (req_done !== 4'b0000) begin
            failures++;
            $display("FAIL single_done_early: got req_done=%b during tx_done cycle, expected 0000", req_done);
        end
        tick(1);
        checks++;
        if (req_done !== 4'b0001 || busy !== 1'b1) begin
            failures++;
            $display("FAIL single_done: got req_done=%b busy=%b, expected 0001 and 1", req_done, busy);
        end
        tick(1);
        checks++;
        if (req_done !== 4'b0000) begin
            failures++;
            $display("FAIL single_done_width: got req_done=%b, expected 0000", req_done);
        end
        wait_idle("single");
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_frame [4] = '{8'h10, 8'h11, 8'h12, 8'h13};
        logic [3:0] exp_oh [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        int last_done = 0;
        apply_reset();
        req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        req_valid = 4'b1111;
        for (int n = 0; n < 4; n++) begin
            wait_en("rr");
            checks++;
            if (req_ready !== exp_oh[n] || uart_tx_data !== exp_frame[n] ||
                grant_id !== 2'(n)) begin
                failures++;
                $display("FAIL rr_grant%0d: got ready=%b data=%h gid=%0d, expected ready=%b data=%h gid=%0d",
                         n, req_ready, uart_tx_data, grant_id, exp_oh[n], exp_frame[n], n);
            end
            if (n > 0) begin
                checks++;
                if (cyc - last_done != GAP + 1) begin
                    failures++;
                    $display("FAIL rr_gap%0d: got launch %0d cycles after done, expected %0d",
                             n, cyc - last_done, GAP + 1);
                end
            end
            req_valid[n] = 1'b0;
            wait_done("rr");
            checks++;
            if (req_done !== exp_oh[n]) begin
                failures++;
                $display("FAIL rr_done%0d: got req_done=%b, expected %b", n, req_done, exp_oh[n]);
            end
            last_done = cyc;
        end
        wait_idle("rr");
    endtask

    task automatic test_withdraw();
        apply_reset();
        ready2_seen = 1'b0;
        req_data = {8'h33, 8'h22, 8'h11, 8'h55};
        req_valid = 4'b0001;
        wait_en("wd");
        req_valid = '0;
        tick(5);
        req_valid = 4'b0100;
        tick(3);
        req_valid = 4'b1000;
        wait_en("wd");
        checks++;
        if (req_ready !== 4'b1000 || grant_id !== 2'd3 || uart_tx_data !== 8'h33) begin
            failures++;
            $display("FAIL withdraw_grant: got ready=%b gid=%0d data=%h, expected 1000 3 33",
                     req_ready, grant_id, uart_tx_data);
        end
        req_valid = '0;
        wait_done("wd");
        checks++;
        if (ready2_seen !== 1'b0) begin
            failures++;
            $display("FAIL withdraw_no_ready2: got req_ready[2] asserted, expected never");
        end
        wait_idle("wd");
    endtask

    task automatic test_spurious_and_reset();
        int dp;
        tick(2);
        dp = done_pulses;
        spur = 1'b1;
        tick(1);
        spur = 1'b0;
        checks++;
        if (req_done !== 4'b0000 || busy !== 1'b0 || uart_tx_en !== 1'b0) begin
            failures++;
            $display("FAIL spurious_idle: got done=%b busy=%b en=%b, expected 0000 0 0",
                     req_done, busy, uart_tx_en);
        end
        tick(2);
        checks++;
        if (done_pulses != dp) begin
            failures++;
            $display("FAIL spurious_pulses: got %0d req_done pulses, expected 0", done_pulses - dp);
        end
        req_data[15:8] = 8'h77;
        req_valid = 4'b0010;
        wait_en("rst");
        checks++;
        if (req_ready !== 4'b0010 || uart_tx_data !== 8'h77) begin
            failures++;
            $display("FAIL midrst_grant: got ready=%b data=%h, expected 0010 77", req_ready, uart_tx_data);
        end
        req_valid = '0;
        tick(6);
        dp = done_pulses;
        sys_reset_n = 1'b0;
        #1;
        checks++;
        if ({busy, uart_tx_en, req_ready, req_done, grant_id, uart_tx_data, timeout_err} !== 21'd0) begin
            failures++;
            $display("FAIL midrst_outputs: got busy=%b en=%b ready=%b done=%b gid=%0d data=%h terr=%b, expected all 0",
                     busy, uart_tx_en, req_ready, req_done, grant_id, uart_tx_data, timeout_err);
        end
        tick(2);
        sys_reset_n = 1'b1;
        tick(CPB * 12);
        checks++;
        if (done_pulses != dp) begin
            failures++;
            $display("FAIL midrst_no_done: got %0d req_done pulses, expected 0", done_pulses - dp);
        end
        req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        req_valid = 4'b1111;
        wait_en("rst");
        checks++;
        if (req_ready !== 4'b0001 || uart_tx_data !== 8'h11) begin
            failures++;
            $display("FAIL midrst_next_grant: got ready=%b data=%h, expected 0001 11", req_ready, uart_tx_data);
        end
        req_valid = '0;
        wait_done("rst");
        wait_idle("rst");
    endtask

    task automatic test_timeout();
`ifdef UART_ARB_TIMEOUT_EN
        int launch;
        int dp;
        int k = 0;
        apply_reset();
        block_done = 1'b1;
        req_data[7:0] = 8'h3C;
        req_valid = 4'b0001;
        wait_en("tmo");
        launch = cyc;
        dp = done_pulses;
        req_valid = '0;
        while (!timeout_err && k < 300) begin
            tick(1);
            k++;
        end
        checks++;
        if (!timeout_err || cyc - launch != TMO + 1) begin
            failures++;
            $display("FAIL timeout_time: got terr=%b at %0d cycles after launch, expected 1 at %0d",
                     timeout_err, cyc - launch, TMO + 1);
        end
        checks++;
        if (req_done !== 4'b0000 || done_pulses != dp) begin
            failures++;
            $display("FAIL timeout_no_done: got req_done=%b pulses=%0d, expected 0000 0",
                     req_done, done_pulses - dp);
        end
        tick(1);
        checks++;
        if (timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL timeout_width: got terr=%b, expected 0", timeout_err);
        end
        block_done = 1'b0;
        wait_idle("tmo");
        req_data[15:8] = 8'h5A;
        req_valid = 4'b0010;
        wait_en("tmo");
        checks++;
        if (req_ready !== 4'b0010 || uart_tx_data !== 8'h5A) begin
            failures++;
            $display("FAIL timeout_recover: got ready=%b data=%h, expected 0010 5A", req_ready, uart_tx_data);
        end
        req_valid = '0;
        wait_done("tmo");
        checks++;
        if (req_done !== 4'b0010) begin
            failures++;
            $display("FAIL timeout_recover_done: got req_done=%b, expected 0010", req_done);
        end
`else
        tick(2);
        checks++;
        if (terr_seen !== 1'b0) begin
            failures++;
            $display("FAIL no_timeout: got timeout_err asserted, expected it to stay 0");
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_round_robin();
        test_withdraw();
        test_spurious_and_reset();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter (8N1 framing, single-cycle uart_tx_en start, single-cycle uart_tx_done on the last cycle of the stop bit) between NUM_REQ requesters.
- Grants requesters in round-robin order and launches one frame per grant.
- Waits for frame completion, reports completion to the granted requester, and enforces an idle guard gap before the next launch.
- Sits between client logic (command/status generators) and the transmitter instance.

Parameters:
- NUM_REQ, 4: number of requesters, 2..16.
- width, 8: data width per frame; must equal the transmitter's width.
- GAP_CYCLES, 2: idle sys_clk cycles between a frame's done and the next launch; 0 allowed.
- TIMEOUT_CYCLES, 60000: max cycles in BUSY before abort; used only with UART_ARB_TIMEOUT_EN; must exceed 10*SYS_CLK_FREQ/BPS.

Ports:
- sys_clk  in  1  single system clock, rising edge.
- sys_reset_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  requester i holds bit i high with data stable until accepted.
- req_data  in  NUM_REQ*width  requester i data at [i*width +: width].
- req_ready  out  NUM_REQ  one-hot, 1-cycle pulse: data of requester i accepted.
- req_done  out  NUM_REQ  one-hot, 1-cycle pulse: requester i's frame fully sent.
- uart_tx_en  out  1  1-cycle frame start to the transmitter.
- uart_tx_data  out  width  frame data to the transmitter.
- uart_tx_done  in  1  frame-complete pulse from the transmitter.
- busy  out  1  high in every state except IDLE.
- grant_id  out  $clog2(NUM_REQ)  index of current or last granted requester.
- timeout_err  out  1  1-cycle pulse on abort (see Optional Feature).

Behaviour:
- Reset (async assert, sync release):
  - All outputs are 0.
  - State is IDLE, gap counter is 0.
  - Round-robin pointer last_grant = NUM_REQ-1, so requester 0 has first priority.
- Every output is registered.
- States: IDLE, LAUNCH, BUSY, GAP.
- IDLE:
  - When any req_valid bit is high at a clock edge, select the winner w: the first set bit searching upward from last_grant+1 modulo NUM_REQ.
  - At that edge: grant_id<=w, last_grant<=w, uart_tx_data<=req_data slice w, req_ready<=onehot(w), uart_tx_en<=1. Go to LAUNCH.
  - A request sampled at edge k therefore sees uart_tx_en and req_ready high during cycle k+1.
- LAUNCH (exactly 1 cycle):
  - req_ready and uart_tx_en are high.
  - Next edge clears both and moves to BUSY.
  - req_valid is ignored here. Requester i may drop valid or present new data from cycle k+2.
- BUSY:
  - On uart_tx_done=1: req_done<=onehot(grant_id) for 1 cycle.
  - Then go to GAP if GAP_CYCLES>0, else to IDLE.
- GAP:
  - Count GAP_CYCLES cycles, then go to IDLE.
  - Requests are not sampled in GAP.
- uart_tx_data holds its value from LAUNCH until the next launch.
- uart_tx_done in IDLE, LAUNCH or GAP is ignored; no req_done is produced.
- A requester dropping req_valid before its req_ready is a withdrawal; it is not granted. Only the level at the sampling edge in IDLE counts.
- A single requester with continuous valid is granted back-to-back; one frame per grant.
- With all requesters valid, the grant order is 0,1,2,3,0,...
- uart_tx_en is never asserted while in BUSY or GAP, so no frame restarts mid-transmission.
- Reset mid-frame:
  - Immediately returns to IDLE with outputs at 0.
  - The in-flight frame is not reported done.
  - The transmitter shares sys_reset_n and resets too.

Optional Feature:
- Macro UART_ARB_TIMEOUT_EN.
- Defined:
  - A 32-bit counter clears on entering BUSY and increments each BUSY cycle.
  - If it reaches TIMEOUT_CYCLES-1 without uart_tx_done, timeout_err pulses 1 cycle, no req_done is issued, and the block goes to GAP (or IDLE if GAP_CYCLES=0).
  - If uart_tx_done and the timeout occur in the same cycle, done wins.
- Not defined: no counter is built, timeout_err is tied 0, and BUSY waits indefinitely.

Decomposition:
- Package uart_ctrl_pkg:
  - State encoding constants ST_IDLE, ST_LAUNCH, ST_BUSY, ST_GAP.
  - Frame length constant BPF=10.
  - Helper for cycles per bit (SYS_CLK_FREQ/BPS), for deriving TIMEOUT_CYCLES.
- Sub-module rr_arbiter: takes req vector and last_grant; returns combinational winner index and any_req. Instantiated once.
- The FSM, data capture and counters stay in uart_tx_arbiter.

Test Plan:
- Reset, then req_valid=4'b0001, data 8'hA5:
  - uart_tx_en and req_ready[0] pulse 1 cycle after sampling; uart_tx_data=8'hA5; busy=1.
  - Serial line carries 0,1,0,1,0,0,1,0,1,1.
  - req_done[0] pulses 1 cycle after uart_tx_done.
- All 4 valid, data 8'h10..8'h13, held until each ready:
  - Grants in order 0,1,2,3 with frames 10,11,12,13.
  - Each launch occurs exactly GAP_CYCLES+1 cycles after the previous req_done.
- Requester 2 raises valid, then drops it before the sampling edge while requester 3 is valid: only requester 3 is granted; no req_ready[2].
- Spurious uart_tx_done in IDLE: no req_done, no state change. Reset asserted mid-BUSY: all outputs 0 the same cycle; next grant goes to requester 0.
- With UART_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=100, transmitter done forced low:
  - timeout_err pulses after 100 BUSY cycles; no req_done.
  - The next request is served normally.
  - Without the macro, timeout_err stays 0.
